// File: rtl/ram_ws_mem.sv
// Byte-addressed big-endian RAM with configurable depth and wait states, driven by the MOV/MOC handshake.
// Define RAM_WS_ALIGN_CHECK_EN to reject misaligned halfword/word accesses with MERR instead of splitting them.
module ram_ws_mem #(
    parameter int ADDR_W      = 8,
    parameter int WAIT_CYCLES = 2
) (
    input  logic        CLK,
    input  logic        RESET,
    input  logic        MOV,
    input  logic        ReadWrite,
    input  logic [2:0]  MS,
    input  logic [31:0] Address,
    input  logic [31:0] DataIn,
    output logic [31:0] DataOut,
    output logic        MOC,
    output logic        MERR
);

    localparam int DEPTH = 2 ** ADDR_W;

    typedef enum logic [1:0] {IDLE, WAIT, DONE} state_t;

    state_t             state_q, state_d;
    logic [3:0]         waitCnt_q, waitCnt_d;
    logic [ADDR_W-1:0]  addr_q, addr_d;
    logic               readWrite_q, readWrite_d;
    logic [2:0]         ms_q, ms_d;
    logic [31:0]        dataIn_q, dataIn_d;
    logic [31:0]        dataOut_q, dataOut_d;
    logic               moc_q, moc_d;
    logic               merr_q, merr_d;

    logic [7:0]         memory [0:DEPTH-1];

    logic [ADDR_W-1:0]  laneAddr [4];
    logic [7:0]         laneRd [4];
    logic [7:0]         laneWr [4];
    logic [3:0]         laneWe;
    logic               commit;
    logic               accessErr;
    logic [31:0]        readVal;
    logic               unusedAddrBits;

    assign unusedAddrBits = ^Address[31:ADDR_W];

    assign commit  = (state_q == WAIT) && (waitCnt_q == 4'd0);
    assign DataOut = dataOut_q;
    assign MOC     = moc_q;
    assign MERR    = merr_q;

    // Lane n always sits at A+n; the ADDR_W-wide sum gives the modulo-depth wrap for free.
    always_comb begin
        for (int i = 0; i < 4; i++) begin
            laneAddr[i] = addr_q + ADDR_W'(i);
            laneRd[i]   = memory[laneAddr[i]];
        end
    end

    always_comb begin
        accessErr = (ms_q[1:0] == 2'b11);
`ifdef RAM_WS_ALIGN_CHECK_EN
        if ((ms_q[1:0] == 2'b01) && addr_q[0]) begin
            accessErr = 1'b1;
        end
        if ((ms_q[1:0] == 2'b10) && (addr_q[1:0] != 2'b00)) begin
            accessErr = 1'b1;
        end
`endif
    end

    always_comb begin
        case (ms_q[1:0])
            2'b00:   readVal = {{24{ms_q[2] & laneRd[0][7]}}, laneRd[0]};
            2'b01:   readVal = {{16{ms_q[2] & laneRd[0][7]}}, laneRd[0], laneRd[1]};
            2'b10:   readVal = {laneRd[0], laneRd[1], laneRd[2], laneRd[3]};
            default: readVal = 32'h0;
        endcase
    end

    // A reset on the commit edge must suppress the write, hence the RESET gate.
    always_comb begin
        laneWe = 4'b0000;
        for (int i = 0; i < 4; i++) begin
            laneWr[i] = 8'h00;
        end
        case (ms_q[1:0])
            2'b00: begin
                laneWe    = 4'b0001;
                laneWr[0] = dataIn_q[7:0];
            end
            2'b01: begin
                laneWe    = 4'b0011;
                laneWr[0] = dataIn_q[15:8];
                laneWr[1] = dataIn_q[7:0];
            end
            2'b10: begin
                laneWe    = 4'b1111;
                laneWr[0] = dataIn_q[31:24];
                laneWr[1] = dataIn_q[23:16];
                laneWr[2] = dataIn_q[15:8];
                laneWr[3] = dataIn_q[7:0];
            end
            default: laneWe = 4'b0000;
        endcase
        if (!(commit && readWrite_q && !accessErr && !RESET)) begin
            laneWe = 4'b0000;
        end
    end

    always_ff @(posedge CLK) begin
        for (int i = 0; i < 4; i++) begin
            if (laneWe[i]) begin
                memory[laneAddr[i]] <= laneWr[i];
            end
        end
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            state_q     <= IDLE;
            waitCnt_q   <= 4'd0;
            addr_q      <= '0;
            readWrite_q <= 1'b0;
            ms_q        <= 3'b000;
            dataIn_q    <= 32'h0;
            dataOut_q   <= 32'h0;
            moc_q       <= 1'b0;
            merr_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            waitCnt_q   <= waitCnt_d;
            addr_q      <= addr_d;
            readWrite_q <= readWrite_d;
            ms_q        <= ms_d;
            dataIn_q    <= dataIn_d;
            dataOut_q   <= dataOut_d;
            moc_q       <= moc_d;
            merr_q      <= merr_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (MOV) state_d = WAIT;
            WAIT:    if (waitCnt_q == 4'd0) state_d = DONE;
            DONE:    if (!MOV) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // WAIT_CYCLES=0 still passes through WAIT once so that the commit lands one edge after capture.
    always_comb begin
        waitCnt_d   = waitCnt_q;
        addr_d      = addr_q;
        readWrite_d = readWrite_q;
        ms_d        = ms_q;
        dataIn_d    = dataIn_q;
        dataOut_d   = dataOut_q;
        moc_d       = moc_q;
        merr_d      = merr_q;
        case (state_q)
            IDLE: begin
                if (MOV) begin
                    addr_d      = Address[ADDR_W-1:0];
                    readWrite_d = ReadWrite;
                    ms_d        = MS;
                    dataIn_d    = DataIn;
                    waitCnt_d   = 4'(WAIT_CYCLES);
                end
            end
            WAIT: begin
                if (waitCnt_q != 4'd0) begin
                    waitCnt_d = waitCnt_q - 4'd1;
                end else begin
                    moc_d  = 1'b1;
                    merr_d = accessErr;
                    if (accessErr) begin
                        dataOut_d = 32'h0;
                    end else if (!readWrite_q) begin
                        dataOut_d = readVal;
                    end
                end
            end
            DONE: begin
                if (!MOV) begin
                    moc_d  = 1'b0;
                    merr_d = 1'b0;
                end
            end
            default: begin
                moc_d  = 1'b0;
                merr_d = 1'b0;
            end
        endcase
    end

endmodule
